difftest_commit_queue: RTL and testbench
========================================

Name: difftest_commit_queue

Overview:
- Parametrised successor to the single-stage difftest commit tap.
- Captures per-cycle commit groups of up to CW lanes from CMT into a DEPTH-entry FIFO and drains them to the difftest sink via a valid/ready handshake, so the sink may stall without perturbing the core.
- Also keeps a retired-instruction counter, a sticky overflow flag, and a commit-hang watchdog.
- Sits beside CMT, enabled only under ENABLE_DIFFTEST.

Parameters:
- CONFIG_DW, 64, register data width.
- CONFIG_P_COMMIT_WIDTH, 1, log2 of commit lanes; CW = 1<<CONFIG_P_COMMIT_WIDTH.
- CONFIG_PC_W, 30, PC width (word address).
- CONFIG_INSN_DW, 32, instruction width.
- CONFIG_LRF_AW, 5, logical register address width.
- CONFIG_P_DEPTH, 3, log2 of FIFO entries; DEPTH = 1<<CONFIG_P_DEPTH, minimum 2.
- CONFIG_TIMEOUT_W, 16, watchdog counter width; TMAX = 2^CONFIG_TIMEOUT_W - 1.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmt_valid  in  CW  per-lane commit fire.
- cmt_pc  in  CONFIG_PC_W*CW  lane PCs.
- cmt_ins  in  CONFIG_INSN_DW*CW  lane instructions.
- cmt_wen  in  CW  lane register write enable.
- cmt_wnum  in  CONFIG_LRF_AW*CW  lane destination register.
- cmt_wdat  in  CONFIG_DW*CW  lane write data.
- cmt_excp  in  1  exception flush this cycle.
- cmt_excp_vect  in  8  exception vector (flush target [7:0]).
- timeout_en  in  1  watchdog enable.
- dft_stall  out  1  almost-full hint to CMT.
- out_valid  out  1  head entry present.
- out_ready  in  1  sink accepts head.
- out_cmt_valid, out_pc, out_ins, out_wen, out_wnum, out_wdat, out_excp, out_excp_vect  out  widths as inputs  head entry fields.
- instret  out  64  count of accepted valid lanes.
- ovf  out  1  sticky: a group was dropped.
- hang  out  1  sticky: watchdog expired.

Behaviour:
- Reset (rst=0, async):
  - wptr = rptr = count = 0.
  - instret = 0, watchdog = 0.
  - ovf = hang = dft_stall = out_valid = 0.
  - Entry storage is not reset; out_* data fields are don't-care while out_valid=0.
  - Reset asserted mid-operation discards all queued entries immediately.
- Push request: push_req = |cmt_valid | cmt_excp.
  - Stored entry = all input fields, with wen masked to cmt_valid & cmt_wen.
  - An all-zero cycle is never queued.
- Pop: pop = out_valid & out_ready.
  - out_valid = (count != 0).
  - out_* are a combinational read of entry[rptr], i.e. data is visible the cycle after push; 1-cycle latency when empty.
- Accept rule: push accepted if count < DEPTH, or if count == DEPTH and pop occurs in the same cycle.
  - Otherwise the group is dropped and ovf set to 1 (sticky until reset).
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers are CONFIG_P_DEPTH bits and wrap naturally.
- count is CONFIG_P_DEPTH+1 bits.
- dft_stall is registered: next value = (count_next >= DEPTH-1).
- instret increments by popcount(cmt_valid) on an accepted push only; dropped groups are not counted. Wraps modulo 2^64.
- Watchdog (only while timeout_en=1):
  - Clears to 0 on any accepted push with |cmt_valid.
  - Otherwise increments, saturating at TMAX.
  - hang set when the counter reaches TMAX; sticky.
  - With timeout_en=0 the counter holds 0 and hang holds its value.
- Exception-only group (cmt_valid=0, cmt_excp=1): queued, does not change instret, does not clear the watchdog.
- Lane order within a group is preserved. Groups leave strictly in arrival order.

Test Plan:
1. Reset, then push CW=2 group {valid=2'b11, pc=0x100,0x101, wen=2'b01} with out_ready=1 → next cycle out_valid=1, out_pc matches, out_wen=2'b01; instret=2; following cycle out_valid=0.
2. Hold out_ready=0, push 9 groups with DEPTH=8 → dft_stall=1 after the 7th push; 9th dropped; ovf=1; instret counts only 8 groups.
3. Full queue, out_ready=1, push on the same cycle → accepted, count stays 8, ovf stays 0, order verified over the next 8 pops.
4. Push {cmt_valid=0, cmt_excp=1, vect=0x2C} → entry appears with out_excp=1, out_excp_vect=0x2C; instret unchanged.
5. CONFIG_TIMEOUT_W=4, timeout_en=1, no commits → hang=1 after 15 cycles; a subsequent commit does not clear hang.
6. Assert rst low asynchronously with 5 queued entries → out_valid, count, ovf, hang, instret all 0 before the next clk edge.

Source files
------------

// File: rtl/difftest_commit_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// difftest_commit_queue: FIFO between CMT commit groups and the difftest sink,
// with retired-instruction counter, sticky overflow flag and hang watchdog.
// Revision: 1.0
// ----------------------------------------------------------------------------
module difftest_commit_queue #(
  parameter int CONFIG_DW             = 64,
  parameter int CONFIG_P_COMMIT_WIDTH = 1,
  parameter int CONFIG_PC_W           = 30,
  parameter int CONFIG_INSN_DW        = 32,
  parameter int CONFIG_LRF_AW         = 5,
  parameter int CONFIG_P_DEPTH        = 3,
  parameter int CONFIG_TIMEOUT_W      = 16
) (
  input  logic                                                      clk,
  input  logic                                                      rst,
  input  logic [(1<<CONFIG_P_COMMIT_WIDTH)-1:0]                     cmt_valid,
  input  logic [CONFIG_PC_W*(1<<CONFIG_P_COMMIT_WIDTH)-1:0]         cmt_pc,
  input  logic [CONFIG_INSN_DW*(1<<CONFIG_P_COMMIT_WIDTH)-1:0]      cmt_ins,
  input  logic [(1<<CONFIG_P_COMMIT_WIDTH)-1:0]                     cmt_wen,
  input  logic [CONFIG_LRF_AW*(1<<CONFIG_P_COMMIT_WIDTH)-1:0]       cmt_wnum,
  input  logic [CONFIG_DW*(1<<CONFIG_P_COMMIT_WIDTH)-1:0]           cmt_wdat,
  input  logic                                                      cmt_excp,
  input  logic [7:0]                                                cmt_excp_vect,
  input  logic                                                      timeout_en,
  output logic                                                      dft_stall,
  output logic                                                      out_valid,
  input  logic                                                      out_ready,
  output logic [(1<<CONFIG_P_COMMIT_WIDTH)-1:0]                     out_cmt_valid,
  output logic [CONFIG_PC_W*(1<<CONFIG_P_COMMIT_WIDTH)-1:0]         out_pc,
  output logic [CONFIG_INSN_DW*(1<<CONFIG_P_COMMIT_WIDTH)-1:0]      out_ins,
  output logic [(1<<CONFIG_P_COMMIT_WIDTH)-1:0]                     out_wen,
  output logic [CONFIG_LRF_AW*(1<<CONFIG_P_COMMIT_WIDTH)-1:0]       out_wnum,
  output logic [CONFIG_DW*(1<<CONFIG_P_COMMIT_WIDTH)-1:0]           out_wdat,
  output logic                                                      out_excp,
  output logic [7:0]                                                out_excp_vect,
  output logic [63:0]                                               instret,
  output logic                                                      ovf,
  output logic                                                      hang
);

  localparam int CW    = 1 << CONFIG_P_COMMIT_WIDTH;
  localparam int DEPTH = 1 << CONFIG_P_DEPTH;
  localparam int AW    = CONFIG_P_DEPTH;
  localparam int CNT_W = CONFIG_P_DEPTH + 1;
  localparam logic [CNT_W-1:0]            FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]            STALL_CNT = CNT_W'(DEPTH - 1);
  localparam logic [CONFIG_TIMEOUT_W-1:0] TMAX      = '1;

  // Entry storage carries no reset; out_valid qualifies it.
  logic [CW-1:0]                mem_valid [DEPTH];
  logic [CONFIG_PC_W*CW-1:0]    mem_pc    [DEPTH];
  logic [CONFIG_INSN_DW*CW-1:0] mem_ins   [DEPTH];
  logic [CW-1:0]                mem_wen   [DEPTH];
  logic [CONFIG_LRF_AW*CW-1:0]  mem_wnum  [DEPTH];
  logic [CONFIG_DW*CW-1:0]      mem_wdat  [DEPTH];
  logic                         mem_excp  [DEPTH];
  logic [7:0]                   mem_vect  [DEPTH];

  logic [AW-1:0]               wptr_q, wptr_d;
  logic [AW-1:0]               rptr_q, rptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [63:0]                 instret_q, instret_d;
  logic [CONFIG_TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic                        ovf_q, ovf_d;
  logic                        hang_q, hang_d;
  logic                        dft_stall_q, dft_stall_d;

  logic        push_req;
  logic        pop;
  logic        accept;
  logic [63:0] lane_cnt;

  assign out_valid = (count_q != '0);
  assign push_req  = (|cmt_valid) | cmt_excp;
  assign pop       = out_valid & out_ready;
  // A full queue still takes a group when the head leaves on the same edge.
  assign accept    = push_req & ((count_q < FULL_CNT) | pop);

  always_comb begin
    lane_cnt = '0;
    for (int i = 0; i < CW; i++) begin
      lane_cnt = lane_cnt + 64'(cmt_valid[i]);
    end
  end

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    instret_d   = instret_q;
    wdog_d      = wdog_q;
    ovf_d       = ovf_q;
    hang_d      = hang_q;

    if (accept) begin
      wptr_d    = wptr_q + AW'(1);
      instret_d = instret_q + lane_cnt;
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (push_req && !accept) begin
      ovf_d = 1'b1;
    end

    // Exception-only groups do not count as forward progress.
    if (!timeout_en) begin
      wdog_d = '0;
    end else if (accept && (|cmt_valid)) begin
      wdog_d = '0;
    end else if (wdog_q != TMAX) begin
      wdog_d = wdog_q + CONFIG_TIMEOUT_W'(1);
    end
    if (timeout_en && (wdog_d == TMAX)) begin
      hang_d = 1'b1;
    end

    dft_stall_d = (count_d >= STALL_CNT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      instret_q   <= '0;
      wdog_q      <= '0;
      ovf_q       <= 1'b0;
      hang_q      <= 1'b0;
      dft_stall_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      instret_q   <= instret_d;
      wdog_q      <= wdog_d;
      ovf_q       <= ovf_d;
      hang_q      <= hang_d;
      dft_stall_q <= dft_stall_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_valid[wptr_q] <= cmt_valid;
      mem_pc[wptr_q]    <= cmt_pc;
      mem_ins[wptr_q]   <= cmt_ins;
      mem_wen[wptr_q]   <= cmt_valid & cmt_wen;
      mem_wnum[wptr_q]  <= cmt_wnum;
      mem_wdat[wptr_q]  <= cmt_wdat;
      mem_excp[wptr_q]  <= cmt_excp;
      mem_vect[wptr_q]  <= cmt_excp_vect;
    end
  end

  assign out_cmt_valid = mem_valid[rptr_q];
  assign out_pc        = mem_pc[rptr_q];
  assign out_ins       = mem_ins[rptr_q];
  assign out_wen       = mem_wen[rptr_q];
  assign out_wnum      = mem_wnum[rptr_q];
  assign out_wdat      = mem_wdat[rptr_q];
  assign out_excp      = mem_excp[rptr_q];
  assign out_excp_vect = mem_vect[rptr_q];

  assign instret   = instret_q;
  assign ovf       = ovf_q;
  assign hang      = hang_q;
  assign dft_stall = dft_stall_q;

endmodule
`default_nettype wire

// File: tb/tb_difftest_commit_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_difftest_commit_queue: directed stimulus with a scoreboard queue and a
// monitor that checks every head entry as the sink accepts it.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_difftest_commit_queue;

  typedef struct packed {
    logic [1:0]   v;
    logic [59:0]  pc;
    logic [63:0]  ins;
    logic [1:0]   wen;
    logic [9:0]   wnum;
    logic [127:0] wdat;
    logic         excp;
    logic [7:0]   vect;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   cmt_valid = '0;
  logic [59:0]  cmt_pc = '0;
  logic [63:0]  cmt_ins = '0;
  logic [1:0]   cmt_wen = '0;
  logic [9:0]   cmt_wnum = '0;
  logic [127:0] cmt_wdat = '0;
  logic         cmt_excp = 1'b0;
  logic [7:0]   cmt_excp_vect = '0;
  logic         timeout_en = 1'b0;
  logic         out_ready = 1'b0;
  logic         dft_stall, out_valid, out_excp, ovf, hang;
  logic [1:0]   out_cmt_valid, out_wen;
  logic [59:0]  out_pc;
  logic [63:0]  out_ins, instret;
  logic [9:0]   out_wnum;
  logic [127:0] out_wdat;
  logic [7:0]   out_excp_vect;

  int n_cmp = 0;
  int n_bad = 0;
  ent_t sb_q[$];

  difftest_commit_queue #(
    .CONFIG_DW(64), .CONFIG_P_COMMIT_WIDTH(1), .CONFIG_PC_W(30),
    .CONFIG_INSN_DW(32), .CONFIG_LRF_AW(5), .CONFIG_P_DEPTH(3),
    .CONFIG_TIMEOUT_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_ins(cmt_ins),
    .cmt_wen(cmt_wen), .cmt_wnum(cmt_wnum), .cmt_wdat(cmt_wdat),
    .cmt_excp(cmt_excp), .cmt_excp_vect(cmt_excp_vect),
    .timeout_en(timeout_en), .dft_stall(dft_stall),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_cmt_valid(out_cmt_valid), .out_pc(out_pc), .out_ins(out_ins),
    .out_wen(out_wen), .out_wnum(out_wnum), .out_wdat(out_wdat),
    .out_excp(out_excp), .out_excp_vect(out_excp_vect),
    .instret(instret), .ovf(ovf), .hang(hang)
  );

  always #5 clk = ~clk;

  function automatic ent_t mk(input logic [1:0] v, input logic [29:0] base,
                              input logic [1:0] wen, input logic excp,
                              input logic [7:0] vect);
    ent_t e;
    e.v    = v;
    e.pc   = {base + 30'd1, base};
    e.ins  = {2'b01, base + 30'd1, 2'b10, base};
    e.wen  = wen;
    e.wnum = {base[4:0] + 5'd1, base[4:0]};
    e.wdat = {34'h0, base ^ 30'h155, 34'h3, base};
    e.excp = excp;
    e.vect = vect;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one group for a single cycle; acc says whether the DUT must keep it.
  task automatic push(input ent_t e, input bit acc);
    ent_t x;
    cmt_valid     = e.v;
    cmt_pc        = e.pc;
    cmt_ins       = e.ins;
    cmt_wen       = e.wen;
    cmt_wnum      = e.wnum;
    cmt_wdat      = e.wdat;
    cmt_excp      = e.excp;
    cmt_excp_vect = e.vect;
    if (acc) begin
      x     = e;
      x.wen = e.v & e.wen;
      sb_q.push_back(x);
    end
    tick();
    cmt_valid = '0;
    cmt_excp  = 1'b0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      ent_t act, exp;
      act = '{v: out_cmt_valid, pc: out_pc, ins: out_ins, wen: out_wen,
              wnum: out_wnum, wdat: out_wdat, excp: out_excp, vect: out_excp_vect};
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL pop_unexpected: got pc %0h with no entry expected", out_pc);
      end else begin
        exp = sb_q.pop_front();
        if (act !== exp) begin
          n_bad++;
          $display("FAIL pop_entry: got v=%0h pc=%0h wen=%0h excp=%0h vect=%0h ins=%0h expected v=%0h pc=%0h wen=%0h excp=%0h vect=%0h ins=%0h",
                   act.v, act.pc, act.wen, act.excp, act.vect, act.ins,
                   exp.v, exp.pc, exp.wen, exp.excp, exp.vect, exp.ins);
        end
      end
    end
  end

  initial begin
    // Reset state
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_instret", instret, 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_hang", 64'(hang), 64'd0);
    check("rst_dft_stall", 64'(dft_stall), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // Single group, sink ready
    out_ready = 1'b1;
    push(mk(2'b11, 30'h100, 2'b01, 1'b0, 8'h00), 1'b1);
    @(negedge clk);
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_instret", instret, 64'd2);
    @(negedge clk);
    check("t1_drained", 64'(out_valid), 64'd0);

    // Fill with sink stalled; ninth group overflows
    tick();
    out_ready = 1'b0;
    for (int g = 0; g < 9; g++) begin
      push(mk((g % 2 == 0) ? 2'b11 : 2'b01, 30'h200 + 30'(16 * g), 2'b10, 1'b0, 8'h00), g < 8);
      @(negedge clk);
      if (g == 5) check("t2_stall_after6", 64'(dft_stall), 64'd0);
      if (g == 6) check("t2_stall_after7", 64'(dft_stall), 64'd1);
      if (g == 7) check("t2_ovf_after8", 64'(ovf), 64'd0);
      if (g == 8) begin
        check("t2_ovf_after9", 64'(ovf), 64'd1);
        check("t2_instret", instret, 64'd14);
      end
    end
    tick();
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    @(negedge clk);
    check("t2_drained", 64'(out_valid), 64'd0);

    // Clear the sticky flag, then push into a full queue while popping
    tick();
    rst = 1'b0;
    sb_q.delete();
    tick();
    rst = 1'b1;
    out_ready = 1'b0;
    for (int g = 0; g < 8; g++) begin
      push(mk(2'b11, 30'h300 + 30'(16 * g), 2'b11, 1'b0, 8'h00), 1'b1);
    end
    @(negedge clk);
    check("t3_full_stall", 64'(dft_stall), 64'd1);
    tick();
    out_ready = 1'b1;
    push(mk(2'b11, 30'h380, 2'b11, 1'b0, 8'h00), 1'b1);
    @(negedge clk);
    check("t3_ovf", 64'(ovf), 64'd0);
    check("t3_stall", 64'(dft_stall), 64'd1);
    check("t3_instret", instret, 64'd18);
    repeat (8) @(negedge clk);
    check("t3_drained", 64'(out_valid), 64'd0);

    // Exception-only group
    push(mk(2'b00, 30'h400, 2'b11, 1'b1, 8'h2C), 1'b1);
    @(negedge clk);
    check("t4_out_valid", 64'(out_valid), 64'd1);
    check("t4_instret", instret, 64'd18);
    @(negedge clk);
    check("t4_drained", 64'(out_valid), 64'd0);

    // Watchdog, 4-bit counter
    tick();
    timeout_en = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    check("t5_hang_at14", 64'(hang), 64'd0);
    tick();
    check("t5_hang_at15", 64'(hang), 64'd1);
    push(mk(2'b01, 30'h500, 2'b01, 1'b0, 8'h00), 1'b1);
    @(negedge clk);
    check("t5_hang_sticky", 64'(hang), 64'd1);
    check("t5_instret", instret, 64'd19);
    tick();
    timeout_en = 1'b0;

    // Asynchronous reset with queued entries
    out_ready = 1'b0;
    for (int g = 0; g < 5; g++) begin
      push(mk(2'b11, 30'h600 + 30'(16 * g), 2'b01, 1'b0, 8'h00), 1'b1);
    end
    @(negedge clk);
    check("t6_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b0;
    sb_q.delete();
    #1;
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_ovf", 64'(ovf), 64'd0);
    check("t6_hang", 64'(hang), 64'd0);
    check("t6_instret", instret, 64'd0);
    check("t6_dft_stall", 64'(dft_stall), 64'd0);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    push(mk(2'b10, 30'h700, 2'b10, 1'b0, 8'h00), 1'b1);
    @(negedge clk);
    check("t6_post_valid", 64'(out_valid), 64'd1);
    check("t6_post_instret", instret, 64'd1);
    @(negedge clk);
    check("t6_post_drained", 64'(out_valid), 64'd0);

    tick();
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
